// File: rtl/conv_tile_sequencer_if.sv
// Handshake bundle between the convolution tile sequencer and its surroundings.
// master: the layer controller/datapath side (drives start, config, stall, idle flags).
// slave : the sequencer itself (drives busy, load_bias, feed_*, pos_*, done, layer_done, cfg_err).
interface conv_tile_sequencer_if #(
  parameter int unsigned N_BITS = 6,
  parameter int unsigned K_BITS = 10
);
  logic              start;
  logic [N_BITS:0]   out_rows;
  logic [N_BITS:0]   out_cols;
  logic [K_BITS-1:0] k_cycles;
  logic              stall;
  logic              sta_idle;
  logic              array_idle;

  logic              busy;
  logic              load_bias;
  logic              feed_valid;
  logic [K_BITS-1:0] feed_count;
  logic [N_BITS-1:0] pos_row;
  logic [N_BITS-1:0] pos_col;
  logic              done;
  logic              layer_done;
  logic              cfg_err;

  modport master (
    output start, out_rows, out_cols, k_cycles, stall, sta_idle, array_idle,
    input  busy, load_bias, feed_valid, feed_count, pos_row, pos_col, done, layer_done, cfg_err
  );

  modport slave (
    input  start, out_rows, out_cols, k_cycles, stall, sta_idle, array_idle,
    output busy, load_bias, feed_valid, feed_count, pos_row, pos_col, done, layer_done, cfg_err
  );
endinterface

// File: rtl/conv_tile_sequencer.sv
// Walks an output feature map in SA_N x SA_N tiles, row-major. For each tile it loads bias,
// feeds k_cycles A/B vectors (pausing on stall), waits for the systolic array to drain,
// signals done, then waits for the array datapath to settle before moving to the next tile.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - conv_tile_sequencer_if.slave: start/config/stall/idle in; busy, load_bias,
//           feed_valid, feed_count, pos_row, pos_col, done, layer_done, cfg_err out
module conv_tile_sequencer #(
  parameter int unsigned MAX_N  = 64,
  parameter int unsigned N_BITS = $clog2(MAX_N),
  parameter int unsigned SA_N   = 4,
  parameter int unsigned K_BITS = 10
) (
  input logic                  clk,
  input logic                  reset,
  conv_tile_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StBias,
    StFeed,
    StDrain,
    StDone,
    StWait,
    StLdone
  } state_e;

  // One bit wider than a coordinate so pos + SA_N cannot wrap at MAX_N.
  localparam logic [N_BITS:0] Step = (N_BITS + 1)'(SA_N);

  state_e            state_q, state_d;
  logic [N_BITS:0]   rows_q, rows_d;
  logic [N_BITS:0]   cols_q, cols_d;
  logic [K_BITS-1:0] k_q, k_d;
  logic [K_BITS-1:0] cnt_q, cnt_d;
  logic [N_BITS-1:0] row_q, row_d;
  logic [N_BITS-1:0] col_q, col_d;
  logic              idle_seen_q, idle_seen_d;
  logic              cfg_err_q, cfg_err_d;

  logic [N_BITS:0]   row_next;
  logic [N_BITS:0]   col_next;
  logic              last_row;
  logic              last_col;
  logic              cfg_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rows_q      <= '0;
      cols_q      <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      idle_seen_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      idle_seen_q <= idle_seen_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  always_comb begin
    row_next = {1'b0, row_q} + Step;
    col_next = {1'b0, col_q} + Step;
    last_row = (row_next >= rows_q);
    last_col = (col_next >= cols_q);
    cfg_ok   = (bus.out_rows != '0) && (bus.out_cols != '0) && (bus.k_cycles != '0);
  end

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    idle_seen_d = 1'b0;
    cfg_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (cfg_ok) begin
            rows_d  = bus.out_rows;
            cols_d  = bus.out_cols;
            k_d     = bus.k_cycles;
            row_d   = '0;
            col_d   = '0;
            cnt_d   = '0;
            state_d = StBias;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StBias: begin
        if (!bus.stall) state_d = StFeed;
      end
      StFeed: begin
        if (!bus.stall) begin
          // Count holds at k-1 after the last vector; it is cleared on the next BIAS entry.
          if (cnt_q == k_q - K_BITS'(1)) state_d = StDrain;
          else                           cnt_d   = cnt_q + K_BITS'(1);
        end
      end
      StDrain: begin
        if (bus.sta_idle && !bus.stall) state_d = StDone;
      end
      StDone: begin
        state_d = StWait;
      end
      StWait: begin
        // idle_seen_q remembers array_idle from the previous WAIT cycle only.
        idle_seen_d = bus.array_idle;
        if (bus.array_idle && idle_seen_q) begin
          if (last_row && last_col) begin
            state_d = StLdone;
          end else begin
            cnt_d   = '0;
            state_d = StBias;
            if (!last_col) begin
              col_d = col_next[N_BITS-1:0];
            end else begin
              col_d = '0;
              row_d = row_next[N_BITS-1:0];
            end
          end
        end
      end
      StLdone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.load_bias  = (state_q == StBias);
  assign bus.feed_valid = (state_q == StFeed) && !bus.stall;
  assign bus.feed_count = cnt_q;
  assign bus.pos_row    = row_q;
  assign bus.pos_col    = col_q;
  assign bus.done       = (state_q == StDone);
  assign bus.layer_done = (state_q == StLdone);
  assign bus.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_conv_tile_sequencer.sv
module tb_conv_tile_sequencer;
  localparam int NB = 6;
  localparam int KB = 10;
  localparam int SA = 4;

  localparam int EvBias  = 0;
  localparam int EvFeed  = 1;
  localparam int EvDone  = 2;
  localparam int EvLdone = 3;
  localparam int EvCfg   = 4;

  typedef struct {
    int kind;
    int row;
    int col;
    int cnt;
  } ev_t;

  logic clk;
  logic reset;

  conv_tile_sequencer_if #(.N_BITS(NB), .K_BITS(KB)) bus ();

  conv_tile_sequencer #(
    .MAX_N (64),
    .N_BITS(NB),
    .SA_N  (SA),
    .K_BITS(KB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  ev_t expq[$];
  bit  ldone_seen = 0;
  int  fv_cycles = 0;
  int  lb_cycles = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int row, input int col, input int cnt);
    ev_t e;
    e.kind = kind;
    e.row  = row;
    e.col  = col;
    e.cnt  = cnt;
    expq.push_back(e);
  endtask

  // Reference model: tiles in row-major order, stepping by SA until past the map edge.
  task automatic push_layer(input int rows, input int cols, input int k);
    for (int r = 0; r < rows; r += SA) begin
      for (int c = 0; c < cols; c += SA) begin
        push_ev(EvBias, r, c, 0);
        for (int i = 0; i < k; i++) push_ev(EvFeed, r, c, i);
        push_ev(EvDone, r, c, 0);
      end
    end
    push_ev(EvLdone, 0, 0, 0);
  endtask

  task automatic observe(input int kind, input int row, input int col, input int cnt);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d pos=(%0d,%0d) cnt=%0d, expected none",
               kind, row, col, cnt);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.row != row || e.col != col || e.cnt != cnt) begin
        errors++;
        $display("FAIL event: got kind=%0d pos=(%0d,%0d) cnt=%0d, expected kind=%0d pos=(%0d,%0d) cnt=%0d",
                 kind, row, col, cnt, e.kind, e.row, e.col, e.cnt);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    bit lb_prev;
    lb_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.load_bias && !lb_prev)
        observe(EvBias, int'(bus.pos_row), int'(bus.pos_col), int'(bus.feed_count));
      if (bus.load_bias) lb_cycles++;
      lb_prev = bus.load_bias;
      if (bus.feed_valid) begin
        fv_cycles++;
        observe(EvFeed, int'(bus.pos_row), int'(bus.pos_col), int'(bus.feed_count));
      end
      if (bus.done) observe(EvDone, int'(bus.pos_row), int'(bus.pos_col), 0);
      if (bus.layer_done) begin
        observe(EvLdone, 0, 0, 0);
        check("busy_in_ldone", bus.busy, 1);
        ldone_seen = 1;
      end
      if (bus.cfg_err) observe(EvCfg, 0, 0, 0);
    end
  end

  task automatic start_layer(input int rows, input int cols, input int k);
    push_layer(rows, cols, k);
    ldone_seen = 0;
    fv_cycles  = 0;
    lb_cycles  = 0;
    @(posedge clk);
    #1;
    bus.stall      = 1'b0;
    bus.sta_idle   = 1'b1;
    bus.array_idle = 1'b1;
    bus.out_rows   = (NB + 1)'(rows);
    bus.out_cols   = (NB + 1)'(cols);
    bus.k_cycles   = KB'(k);
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    // Scrambled config must not disturb the running layer.
    bus.out_rows = (NB + 1)'($urandom);
    bus.out_cols = (NB + 1)'($urandom);
    bus.k_cycles = KB'($urandom);
  endtask

  task automatic finish_layer(input bit rnd);
    int n;
    n = 0;
    while (!ldone_seen && n < 20000) begin
      @(posedge clk);
      #1;
      if (rnd) begin
        bus.stall      = ($urandom % 100) < 25;
        bus.sta_idle   = ($urandom % 100) < 60;
        bus.array_idle = ($urandom % 100) < 70;
        bus.start      = ($urandom % 8) == 0;
        bus.out_rows   = (NB + 1)'($urandom);
        bus.out_cols   = (NB + 1)'($urandom);
        bus.k_cycles   = KB'($urandom % 4);
      end else begin
        bus.stall      = 1'b0;
        bus.sta_idle   = 1'b1;
        bus.array_idle = 1'b1;
      end
      n++;
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    check("layer_done_seen", ldone_seen, 1);
    check("queue_drained", expq.size(), 0);
    expq.delete();
  endtask

  initial begin
    int pat[4];
    int n;
    bit hit;

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.out_rows   = '0;
    bus.out_cols   = '0;
    bus.k_cycles   = '0;
    bus.stall      = 1'b0;
    bus.sta_idle   = 1'b0;
    bus.array_idle = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_load_bias", bus.load_bias, 0);
    check("rst_feed_valid", bus.feed_valid, 0);
    check("rst_feed_count", bus.feed_count, 0);
    check("rst_pos", {bus.pos_row, bus.pos_col}, 0);
    check("rst_done_ldone", {bus.done, bus.layer_done}, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 8x8, k=3, no stall.
    start_layer(8, 8, 3);
    finish_layer(0);
    check("l8x8_bias_cycles", lb_cycles, 4);
    check("l8x8_feed_cycles", fv_cycles, 12);

    // 6x5, k=1: partial edge tiles.
    start_layer(6, 5, 1);
    finish_layer(0);
    check("l6x5_feed_cycles", fv_cycles, 4);

    // k=4 with a two-cycle stall while feed_count is 1.
    start_layer(4, 4, 4);
    hit = 0;
    for (n = 0; n < 50 && !hit; n++) begin
      @(negedge clk);
      hit = bus.feed_valid && (bus.feed_count == 0);
    end
    check("stall_reach_feed", hit, 1);
    @(posedge clk);
    #1;
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_fv_low", bus.feed_valid, 0);
      check("stall_cnt_hold", bus.feed_count, 1);
      @(posedge clk);
      #1;
    end
    bus.stall = 1'b0;
    finish_layer(0);
    check("stall_feed_cycles", fv_cycles, 4);

    // Rejected configurations.
    for (int i = 0; i < 2; i++) begin
      push_ev(EvCfg, 0, 0, 0);
      @(posedge clk);
      #1;
      bus.start    = 1'b1;
      bus.out_rows = (i == 0) ? 7'd8 : 7'd0;
      bus.out_cols = 7'd8;
      bus.k_cycles = (i == 0) ? 10'd0 : 10'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("cfg_err_pulse", bus.cfg_err, 1);
      check("cfg_err_busy", bus.busy, 0);
      @(negedge clk);
      check("cfg_err_once", bus.cfg_err, 0);
      check("cfg_err_busy_after", bus.busy, 0);
    end
    check("cfg_queue_drained", expq.size(), 0);

    // WAIT needs array_idle on two consecutive cycles: pattern 1,0,1,1.
    start_layer(8, 4, 1);
    bus.array_idle = 1'b0;
    hit = 0;
    for (n = 0; n < 50 && !hit; n++) begin
      @(negedge clk);
      hit = bus.done;
    end
    check("wait_reach_done", hit, 1);
    pat = '{1, 0, 1, 1};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus.array_idle = pat[i][0];
      @(negedge clk);
      check("wait_no_advance", bus.load_bias, 0);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wait_advanced", bus.load_bias, 1);
    check("wait_next_pos", {bus.pos_row, bus.pos_col}, {6'd4, 6'd0});
    finish_layer(0);

    // Reset asserted mid-FEED aborts silently.
    start_layer(8, 8, 4);
    hit = 0;
    for (n = 0; n < 50 && !hit; n++) begin
      @(negedge clk);
      hit = bus.feed_valid;
    end
    check("rst_reach_feed", hit, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    expq.delete();
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_feed_valid", bus.feed_valid, 0);
    check("abort_pos", {bus.pos_row, bus.pos_col}, 0);
    check("abort_feed_count", bus.feed_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    hit = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done || bus.layer_done || bus.busy) hit = 1;
    end
    check("abort_quiet", hit, 0);

    // Full MAX_N map: coordinates reach 60 and the +SA_N step must not wrap.
    start_layer(64, 64, 1);
    finish_layer(0);
    check("max_bias_cycles", lb_cycles, 256);

    // Randomized layers with random stall/idle and ignored mid-layer starts.
    for (int t = 0; t < 6; t++) begin
      start_layer($urandom_range(1, 20), $urandom_range(1, 20), $urandom_range(1, 5));
      finish_layer(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
